// File: rtl/hub75_pkg.sv
// Shared types and width helpers for the HUB75 scan engine.
package hub75_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } hub75_state_t;

    localparam int PH_W = 2;

    // Ceiling log2, never below 1 so single-entry counters still get a bit.
    function automatic int hub75_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

    function automatic int hub75_row_w(input int height);
        return hub75_clog2(height / 2);
    endfunction

endpackage

// File: rtl/hub75_mem_if.sv
// Framebuffer read port (port B of dual_port_memory) seen from the scan engine.
interface hub75_mem_if #(
    parameter int ADDR_W = 14,
    parameter int BPP    = 12
);
    // Read strobe, no back-pressure: mem_re=1 with mem_addr in cycle n means
    // mem_data holds that word throughout cycle n+1; mem_data is don't-care otherwise.
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [BPP-1:0]    mem_data;

    modport master (output mem_addr, output mem_re, input mem_data);
    modport slave  (input mem_addr, input mem_re, output mem_data);
endinterface

// File: rtl/hub75_oe_timer.sv
// DISPLAY period down-counter with optional brightness gating of oe.
// Optional feature macro: HUB75_BRIGHTNESS_EN.
module hub75_oe_timer
    import hub75_pkg::*;
#(
    parameter int BPC       = 4,
    parameter int BASE_TIME = 32,
    parameter int PW        = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [PW-1:0] plane,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]    brightness,
`endif
    output logic          oe_n,
    output logic          done
);
    localparam int TW = hub75_clog2(BASE_TIME << (BPC - 1)) + 1;

    logic [TW-1:0] period;
    logic [TW-1:0] on_len;
    logic [TW-1:0] cnt;
    logic [TW-1:0] thr;
    logic          active;
`ifdef HUB75_BRIGHTNESS_EN
    logic [TW+7:0] prod;
`endif

    always_comb begin
        period = TW'(BASE_TIME) << plane;
`ifdef HUB75_BRIGHTNESS_EN
        prod   = (TW + 8)'(period) * (TW + 8)'(brightness);
        on_len = prod[TW+7:8];
`else
        on_len = period;
`endif
    end

    assign done = active && (cnt == '0);

    // cnt runs period-1 down to 0; oe stays low while cnt >= period-on_len.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            thr    <= '0;
            active <= 1'b0;
            oe_n   <= 1'b1;
        end else if (load) begin
            cnt    <= period - TW'(1);
            thr    <= period - on_len;
            active <= 1'b1;
            oe_n   <= (on_len == '0);
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
                oe_n   <= 1'b1;
            end else begin
                cnt  <= cnt - TW'(1);
                oe_n <= !((cnt - TW'(1)) >= thr);
            end
        end
    end
endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 scan engine: reads the framebuffer and drives BCM-modulated panel pins.
// Optional feature macro: HUB75_BRIGHTNESS_EN (global dimming port).
module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int HEIGHT    = 64,
    parameter int BPC       = 4,
    parameter int BPP       = 12,
    parameter int CHAINED   = 1,
    parameter int BASE_TIME = 32,
    parameter int ADDR_W    = 14
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]                          brightness,
`endif
    hub75_mem_if.master                         mem,
    output logic                                sclk,
    output logic                                lat,
    output logic                                oe,
    output logic [hub75_row_w(HEIGHT)-1:0]      row_addr,
    output logic                                r0,
    output logic                                g0,
    output logic                                b0,
    output logic                                r1,
    output logic                                g1,
    output logic                                b1,
    output logic                                frame_done,
    output hub75_state_t                        dbg_state
);
    localparam int LINE = WIDTH * CHAINED;
    localparam int ROWS = HEIGHT / 2;
    localparam int RW   = hub75_row_w(HEIGHT);
    localparam int CW   = hub75_clog2(LINE);
    localparam int PW   = hub75_clog2(BPC);

    hub75_state_t   state;
    logic [RW-1:0]  row;
    logic [RW-1:0]  nxt_row;
    logic [PW-1:0]  plane;
    logic [CW-1:0]  col;
    logic [PH_W-1:0] ph;
    logic [BPP-1:0] top_word;
    logic           last_col;
    logic           last_plane;
    logic           last_row;
    logic           oe_done;

    function automatic logic [ADDR_W-1:0] pix_addr(input int r, input int c);
        return ADDR_W'(r * LINE + c);
    endfunction

    function automatic logic [2:0] plane_bits(input logic [BPP-1:0] w, input logic [PW-1:0] p);
        logic [BPC-1:0] cr;
        logic [BPC-1:0] cg;
        logic [BPC-1:0] cb;
        cr = w[3*BPC-1 -: BPC];
        cg = w[2*BPC-1 -: BPC];
        cb = w[BPC-1:0];
        return {cr[p], cg[p], cb[p]};
    endfunction

    assign last_col   = (col == CW'(LINE - 1));
    assign last_plane = (plane == PW'(BPC - 1));
    assign last_row   = (row == RW'(ROWS - 1));
    assign dbg_state  = state;

    always_comb begin
        nxt_row = row;
        if (last_plane) nxt_row = last_row ? '0 : row + RW'(1);
    end

    hub75_oe_timer #(
        .BPC       (BPC),
        .BASE_TIME (BASE_TIME),
        .PW        (PW)
    ) u_oe_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (state == LATCH),
        .plane      (plane),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .oe_n       (oe),
        .done       (oe_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            row          <= '0;
            plane        <= '0;
            col          <= '0;
            ph           <= '0;
            top_word     <= '0;
            mem.mem_addr <= '0;
            mem.mem_re   <= 1'b0;
            sclk         <= 1'b0;
            lat          <= 1'b0;
            row_addr     <= '0;
            {r0, g0, b0} <= 3'b000;
            {r1, g1, b1} <= 3'b000;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state        <= SHIFT;
                        row          <= '0;
                        plane        <= '0;
                        col          <= '0;
                        ph           <= '0;
                        mem.mem_addr <= pix_addr(0, 0);
                        mem.mem_re   <= 1'b1;
                    end
                end
                SHIFT: begin
                    ph <= ph + PH_W'(1);
                    unique case (ph)
                        2'd0: mem.mem_addr <= pix_addr(int'(row) + ROWS, int'(col));
                        2'd1: begin
                            top_word   <= mem.mem_data;
                            mem.mem_re <= 1'b0;
                        end
                        // Colour changes with the sclk fall so it is settled a full clock before the rise.
                        2'd2: begin
                            {r0, g0, b0} <= plane_bits(top_word, plane);
                            {r1, g1, b1} <= plane_bits(mem.mem_data, plane);
                            sclk         <= 1'b0;
                        end
                        default: begin
                            sclk <= 1'b1;
                            if (last_col) begin
                                state <= BLANK;
                            end else begin
                                col          <= col + CW'(1);
                                mem.mem_addr <= pix_addr(int'(row), int'(col) + 1);
                                mem.mem_re   <= 1'b1;
                            end
                        end
                    endcase
                end
                BLANK: begin
                    sclk       <= 1'b0;
                    mem.mem_re <= 1'b0;
                    lat        <= 1'b1;
                    row_addr   <= row;
                    state      <= LATCH;
                end
                LATCH: begin
                    lat   <= 1'b0;
                    state <= DISPLAY;
                end
                DISPLAY: begin
                    if (oe_done) begin
                        row   <= nxt_row;
                        plane <= last_plane ? '0 : plane + PW'(1);
                        col   <= '0;
                        ph    <= '0;
                        if (last_plane && last_row) frame_done <= 1'b1;
                        // enable only matters at a frame boundary; mid-frame the scan always continues.
                        if (!(last_plane && last_row) || enable) begin
                            state        <= SHIFT;
                            mem.mem_addr <= pix_addr(int'(nxt_row), 0);
                            mem.mem_re   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
